wbu_stage_buffer: RTL

- Parametrised write-back stage buffer for an N-way superscalar core. Replaces the single-way, fixed-depth per-field buffers.
- Each way has one independent FIFO holding a bundled write-back record: {rd_we, rd_addr, rd_data, pid}.
- Each FIFO has standard valid/ready handshakes on both sides and a synchronous flush.
- Sits between the EXU/LSU result stage and the register-file write port.

---
 rtl/wbu_pkg.sv | 25 ++
 rtl/wbu_way_fifo.sv | 67 ++++++
 rtl/wbu_stage_buffer.sv | 104 ++++++++++
 3 files changed

// File: rtl/wbu_pkg.sv
// Shared types and default widths for the write-back stage buffer.
// Optional debug fields (inst, inst_addr) are carried when WBU_DEBUG_EN is defined.
package wbu_pkg;

    localparam int WBU_NUM_WAYS = 2;
    localparam int WBU_DEPTH    = 4;
    localparam int WBU_DATA_W   = 64;
    localparam int WBU_ADDR_W   = 5;
    localparam int WBU_PID_W    = 2;
    localparam int WBU_INST_W   = 32;

    // Write-back record at default widths; the top builds its own record
    // type from its parameters with the same field order.
    typedef struct packed {
        logic                  rd_we;
        logic [WBU_ADDR_W-1:0] rd_addr;
        logic [WBU_DATA_W-1:0] rd_data;
        logic [WBU_PID_W-1:0]  pid;
`ifdef WBU_DEBUG_EN
        logic [WBU_INST_W-1:0] inst;
        logic [WBU_INST_W-1:0] inst_addr;
`endif
    } wbu_rec_t;

endpackage

// File: rtl/wbu_way_fifo.sv
// Single-way show-ahead FIFO of write-back records.
// Ready depends only on the registered count; head is read straight from storage.
module wbu_way_fifo
    import wbu_pkg::*;
#(
    parameter int  DEPTH = WBU_DEPTH,
    parameter type rec_t = wbu_rec_t,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  rec_t             in_rec,
    output logic             out_valid,
    input  logic             out_ready,
    output rec_t             out_rec,
    output logic [CNT_W-1:0] count
);

    rec_t             mem [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic             push;
    logic             pop;

    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign out_rec   = mem[rptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Storage is not reset; a write during flush is harmless since wptr is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr] <= in_rec;
        end
    end

    // Pointer and occupancy tracking; flush overrides any push/pop.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + PTR_W'(1);
            end
            if (pop) begin
                rptr <= rptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/wbu_stage_buffer.sv
// N-way write-back stage buffer: one independent FIFO per way between the
// result stage and the register-file write port. Define WBU_DEBUG_EN to carry
// inst/inst_addr alongside each record.
module wbu_stage_buffer
    import wbu_pkg::*;
#(
    parameter int NUM_WAYS = WBU_NUM_WAYS,
    parameter int DEPTH    = WBU_DEPTH,
    parameter int DATA_W   = WBU_DATA_W,
    parameter int ADDR_W   = WBU_ADDR_W,
    parameter int PID_W    = WBU_PID_W
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  flush_i,
    input  logic [NUM_WAYS-1:0]                   in_valid_i,
    output logic [NUM_WAYS-1:0]                   in_ready_o,
    input  logic [NUM_WAYS-1:0]                   rd_we_i,
    input  logic [NUM_WAYS*ADDR_W-1:0]            rd_addr_i,
    input  logic [NUM_WAYS*DATA_W-1:0]            rd_data_i,
    input  logic [NUM_WAYS*PID_W-1:0]             pid_i,
`ifdef WBU_DEBUG_EN
    input  logic [NUM_WAYS*32-1:0]                inst_i,
    input  logic [NUM_WAYS*32-1:0]                inst_addr_i,
    output logic [NUM_WAYS*32-1:0]                inst_o,
    output logic [NUM_WAYS*32-1:0]                inst_addr_o,
`endif
    output logic [NUM_WAYS-1:0]                   out_valid_o,
    input  logic [NUM_WAYS-1:0]                   out_ready_i,
    output logic [NUM_WAYS-1:0]                   rd_we_o,
    output logic [NUM_WAYS*ADDR_W-1:0]            rd_addr_o,
    output logic [NUM_WAYS*DATA_W-1:0]            rd_data_o,
    output logic [NUM_WAYS*PID_W-1:0]             pid_o,
    output logic [NUM_WAYS*$clog2(DEPTH+1)-1:0]   count_o,
    output logic                                  overflow_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef struct packed {
        logic              rd_we;
        logic [ADDR_W-1:0] rd_addr;
        logic [DATA_W-1:0] rd_data;
        logic [PID_W-1:0]  pid;
`ifdef WBU_DEBUG_EN
        logic [31:0]       inst;
        logic [31:0]       inst_addr;
`endif
    } rec_t;

    logic ovf_hit;

    for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
        rec_t in_rec;
        rec_t out_rec;

        assign in_rec.rd_we   = rd_we_i[w];
        assign in_rec.rd_addr = rd_addr_i[w*ADDR_W +: ADDR_W];
        assign in_rec.rd_data = rd_data_i[w*DATA_W +: DATA_W];
        assign in_rec.pid     = pid_i[w*PID_W +: PID_W];
`ifdef WBU_DEBUG_EN
        assign in_rec.inst      = inst_i[w*32 +: 32];
        assign in_rec.inst_addr = inst_addr_i[w*32 +: 32];
`endif

        wbu_way_fifo #(
            .DEPTH (DEPTH),
            .rec_t (rec_t)
        ) u_fifo (
            .clk       (clk),
            .reset_n   (reset_n),
            .flush     (flush_i),
            .in_valid  (in_valid_i[w]),
            .in_ready  (in_ready_o[w]),
            .in_rec    (in_rec),
            .out_valid (out_valid_o[w]),
            .out_ready (out_ready_i[w]),
            .out_rec   (out_rec),
            .count     (count_o[w*CNT_W +: CNT_W])
        );

        // Write enable must never leak from stale storage when the way is empty.
        assign rd_we_o[w]                    = out_rec.rd_we & out_valid_o[w];
        assign rd_addr_o[w*ADDR_W +: ADDR_W] = out_rec.rd_addr;
        assign rd_data_o[w*DATA_W +: DATA_W] = out_rec.rd_data;
        assign pid_o[w*PID_W +: PID_W]       = out_rec.pid;
`ifdef WBU_DEBUG_EN
        assign inst_o[w*32 +: 32]      = out_rec.inst;
        assign inst_addr_o[w*32 +: 32] = out_rec.inst_addr;
`endif
    end

    assign ovf_hit = (|(in_valid_i & ~in_ready_o)) & ~flush_i;

    // Sticky diagnostic: producer pushed against a full way; cleared only by reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            overflow_o <= 1'b0;
        end else if (ovf_hit) begin
            overflow_o <= 1'b1;
        end
    end

endmodule
